fetch_realign_ctrl: RTL and testbench

- Sequences the front-end fetch path: generates fetch addresses to the I$ and forwards I$ responses to the instruction re-aligner.
- Gates every fetch on instruction-queue credits, limits outstanding requests and discards in-flight responses after a flush.
- Sits between the PC/redirect logic, the I$ request/response interface, the re-aligner and the instruction queue.

---
 rtl/fetch_realign_ctrl_pkg.sv | 21 ++
 rtl/fetch_credit_cnt.sv | 58 +++++
 rtl/fetch_realign_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_realign_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_realign_ctrl_pkg.sv
// Shared front-end fetch definitions: FSM state encoding, fetch geometry and
// the credit-counter width helper.
package fetch_realign_ctrl_pkg;

   // Virtual address width used by the front end.
   localparam int unsigned VLEN            = 39;
   localparam int unsigned FETCH_WIDTH     = 32;
   localparam int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } fetch_ctrl_state_e;

   // Bits needed to hold any value 0..max_val inclusive.
   function automatic int unsigned credit_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/fetch_credit_cnt.sv
// Up/down counter for instruction-queue credits. All deltas of a cycle are
// applied in one update; a load replaces the count. Results outside
// 0..MAX_VAL are clamped and flagged by assertions.
module fetch_credit_cnt #(
   parameter int unsigned MAX_VAL = 4,
   parameter int unsigned CW      = 3
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [CW-1:0] i_inc,
   input  logic [CW-1:0] i_dec,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   output logic [CW-1:0] o_count,
   output logic [CW-1:0] o_count_next
);

   localparam logic [CW:0] C_MAX = (CW+1)'(MAX_VAL);

   logic [CW-1:0] r_count;
   logic [CW:0]   w_up;
   logic [CW:0]   w_sum;
   logic [CW-1:0] w_next;
   logic          w_over;
   logic          w_under;

   // Combine increments and decrements, then clamp and flag out-of-range results.
   always_comb begin
      w_up    = {1'b0, r_count} + {1'b0, i_inc};
      w_sum   = w_up - {1'b0, i_dec};
      w_over  = 1'b0;
      w_under = 1'b0;
      w_next  = w_sum[CW-1:0];
      if (i_load) begin
         w_over = ({1'b0, i_load_val} > C_MAX);
         w_next = w_over ? C_MAX[CW-1:0] : i_load_val;
      end else if (w_up < {1'b0, i_dec}) begin
         w_under = 1'b1;
         w_next  = '0;
      end else if (w_sum > C_MAX) begin
         w_over = 1'b1;
         w_next = C_MAX[CW-1:0];
      end
   end

   // Credit register; the front end starts with the whole queue free.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_count <= C_MAX[CW-1:0];
      else          r_count <= w_next;
   end

   assign o_count      = r_count;
   assign o_count_next = w_next;

   a_no_overflow:  assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_over);
   a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_under);

endmodule

// File: rtl/fetch_realign_ctrl.sv
// Front-end fetch sequencer: issues I$ fetch addresses gated by queue credits
// and an outstanding-request limit, forwards responses to the re-aligner and
// drops responses that were in flight when a flush arrived.
module fetch_realign_ctrl #(
   parameter int unsigned      VLEN            = fetch_realign_ctrl_pkg::VLEN,
   parameter int unsigned      FETCH_WIDTH     = fetch_realign_ctrl_pkg::FETCH_WIDTH,
   parameter int unsigned      INSTR_PER_FETCH = FETCH_WIDTH / 16,
   parameter int unsigned      IQ_DEPTH        = 4,
   parameter int unsigned      MAX_OUTSTANDING = 2,
   parameter logic [VLEN-1:0]  BOOT_ADDR       = VLEN'(64'h8000_0000)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_i,
   input  logic [VLEN-1:0]                    flush_addr_i,
   output logic                               ireq_valid_o,
   input  logic                               ireq_ready_i,
   output logic [VLEN-1:0]                    ireq_vaddr_o,
   input  logic                               irsp_valid_i,
   input  logic [VLEN-1:0]                    irsp_vaddr_i,
   output logic                               realign_valid_o,
   output logic [VLEN-1:0]                    realign_addr_o,
   output logic                               realign_flush_o,
   input  logic [INSTR_PER_FETCH-1:0]         realign_instr_valid_i,
   input  logic                               iq_pop_i,
   output logic [$clog2(IQ_DEPTH+1)-1:0]      credits_o
);

   import fetch_realign_ctrl_pkg::*;

   localparam int unsigned CW = credit_w(IQ_DEPTH);
   localparam int unsigned OW = credit_w(MAX_OUTSTANDING);

   localparam logic [CW-1:0] C_IPF   = CW'(INSTR_PER_FETCH);
   localparam logic [CW-1:0] C_DEPTH = CW'(IQ_DEPTH);
   localparam logic [OW-1:0] C_MAXO  = OW'(MAX_OUTSTANDING);

   if (FETCH_WIDTH != 32) begin : g_fetch_width_check
      $error("fetch_realign_ctrl: only FETCH_WIDTH = 32 is supported");
   end

   fetch_ctrl_state_e r_state;
   fetch_ctrl_state_e w_state_next;

   logic [VLEN-1:0] r_pc;
   logic [OW-1:0]   r_outstanding;
   logic [OW-1:0]   r_kill;

   logic [CW-1:0]   w_credits;
   logic [CW-1:0]   w_credits_d;
   logic [CW-1:0]   w_inc;
   logic [CW-1:0]   w_dec;
   logic [CW-1:0]   w_used;
   logic [CW-1:0]   w_load_val;
   logic [OW-1:0]   w_outstanding_d;
   logic [OW-1:0]   w_kill_d;
   logic            w_issue_ok;
   logic            w_issue_ok_d;
   logic            w_fire;
   logic            w_rsp;
   logic            w_rsp_kill;

   // Issue gating, handshake and response classification.
   always_comb begin
      w_issue_ok   = (w_credits >= C_IPF) && (r_outstanding < C_MAXO) && !flush_i;
      w_fire       = ireq_valid_o && ireq_ready_i;
      // A response with nothing outstanding is spurious and ignored.
      w_rsp        = irsp_valid_i && (r_outstanding != '0);
      w_rsp_kill   = w_rsp && (r_kill != '0);
      w_used       = CW'($countones(realign_instr_valid_i));
      w_outstanding_d = r_outstanding + OW'(w_fire) - OW'(w_rsp);
      // A flush turns every request still in flight into a stale response.
      w_kill_d     = flush_i ? w_outstanding_d : (r_kill - OW'(w_rsp_kill));
      w_issue_ok_d = (w_credits_d >= C_IPF) && (w_outstanding_d < C_MAXO);
   end

   // Per-cycle credit deltas, summed into a single counter update.
   always_comb begin
      w_inc = '0;
      if (w_rsp) w_inc = w_rsp_kill ? C_IPF : (C_IPF - w_used);
      if (iq_pop_i && !flush_i) w_inc = w_inc + CW'(1);
      w_dec      = w_fire ? C_IPF : '0;
      // Queue is flushed too; only stale responses still hold reservations.
      w_load_val = C_DEPTH - CW'(INSTR_PER_FETCH * 32'(w_kill_d));
   end

   fetch_credit_cnt #(
      .MAX_VAL (IQ_DEPTH),
      .CW      (CW)
   ) u_credit_cnt (
      .i_clk        (clk_i),
      .i_rst_n      (rst_ni),
      .i_inc        (w_inc),
      .i_dec        (w_dec),
      .i_load       (flush_i),
      .i_load_val   (w_load_val),
      .o_count      (w_credits),
      .o_count_next (w_credits_d)
   );

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= BOOT;
      else         r_state <= w_state_next;
   end

   // FSM next-state logic; flush overrides every other transition.
   always_comb begin
      w_state_next = r_state;
      if (flush_i) begin
         w_state_next = RUN;
      end else begin
         case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     if (!w_issue_ok) w_state_next = STALL;
            STALL:   if (w_issue_ok_d) w_state_next = RUN;
            default: w_state_next = BOOT;
         endcase
      end
   end

   // FSM outputs towards the I$ and the re-aligner.
   always_comb begin
      ireq_valid_o    = (r_state == RUN) && w_issue_ok;
      realign_valid_o = w_rsp && !w_rsp_kill && !flush_i;
      realign_flush_o = flush_i;
   end

   // Fetch PC, outstanding-request and stale-response counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pc          <= BOOT_ADDR;
         r_outstanding <= '0;
         r_kill        <= '0;
      end else begin
         if (flush_i)     r_pc <= flush_addr_i;
         else if (w_fire) r_pc <= {r_pc[VLEN-1:2], 2'b00} + VLEN'(4);
         r_outstanding <= w_outstanding_d;
         r_kill        <= w_kill_d;
      end
   end

   assign ireq_vaddr_o   = r_pc;
   assign realign_addr_o = irsp_vaddr_i;
   assign credits_o      = w_credits;

endmodule

// File: tb/tb_fetch_realign_ctrl.sv
// Directed bench for fetch_realign_ctrl with a queue-based scoreboard for
// issued requests and forwarded responses.
module tb_fetch_realign_ctrl;

   localparam int unsigned VL = 39;
   localparam logic [VL-1:0] BASE = VL'(64'h8000_0000);

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          flush_i = 1'b0;
   logic [VL-1:0] flush_addr_i = '0;
   logic          ireq_valid_o;
   logic          ireq_ready_i = 1'b0;
   logic [VL-1:0] ireq_vaddr_o;
   logic          irsp_valid_i = 1'b0;
   logic [VL-1:0] irsp_vaddr_i = '0;
   logic          realign_valid_o;
   logic [VL-1:0] realign_addr_o;
   logic          realign_flush_o;
   logic [1:0]    realign_instr_valid_i = '0;
   logic          iq_pop_i = 1'b0;
   logic [2:0]    credits_o;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [VL-1:0] exp_req[$];
   logic [VL-1:0] exp_rsp[$];

   fetch_realign_ctrl #(
      .VLEN            (VL),
      .FETCH_WIDTH     (32),
      .INSTR_PER_FETCH (2),
      .IQ_DEPTH        (4),
      .MAX_OUTSTANDING (2),
      .BOOT_ADDR       (BASE)
   ) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .flush_i               (flush_i),
      .flush_addr_i          (flush_addr_i),
      .ireq_valid_o          (ireq_valid_o),
      .ireq_ready_i          (ireq_ready_i),
      .ireq_vaddr_o          (ireq_vaddr_o),
      .irsp_valid_i          (irsp_valid_i),
      .irsp_vaddr_i          (irsp_vaddr_i),
      .realign_valid_o       (realign_valid_o),
      .realign_addr_o        (realign_addr_o),
      .realign_flush_o       (realign_flush_o),
      .realign_instr_valid_i (realign_instr_valid_i),
      .iq_pop_i              (iq_pop_i),
      .credits_o             (credits_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [VL-1:0] a(input int unsigned off);
      return BASE + VL'(off);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard monitor: every accepted request and forwarded response is
   // matched against the next expected address.
   always @(negedge clk_i) begin
      if (ireq_valid_o && ireq_ready_i) begin
         n_cmp++;
         if (exp_req.size() == 0) begin
            n_err++;
            $display("FAIL req_unexpected: got request at %h, required none", ireq_vaddr_o);
         end else begin
            logic [VL-1:0] e;
            e = exp_req.pop_front();
            if (ireq_vaddr_o !== e) begin
               n_err++;
               $display("FAIL req_addr: got %h, required %h", ireq_vaddr_o, e);
            end
         end
      end
      if (realign_valid_o) begin
         n_cmp++;
         if (exp_rsp.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: got forward of %h, required none", realign_addr_o);
         end else begin
            logic [VL-1:0] e;
            e = exp_rsp.pop_front();
            if (realign_addr_o !== e) begin
               n_err++;
               $display("FAIL rsp_addr: got %h, required %h", realign_addr_o, e);
            end
         end
      end
   end

   initial begin
      // Reset state.
      ireq_ready_i = 1'b1;
      tick(); tick();
      chk("rst_credits", 64'(credits_o), 64'd4);
      chk("rst_ireq_valid", 64'(ireq_valid_o), 64'd0);
      chk("rst_vaddr", 64'(ireq_vaddr_o), 64'(BASE));
      chk("rst_flush", 64'(realign_flush_o), 64'd0);

      // Boot: one idle cycle, then back-to-back requests until credits run out.
      exp_req.push_back(a('h0));
      exp_req.push_back(a('h4));
      rst_ni = 1'b1;
      #2 chk("boot_no_req", 64'(ireq_valid_o), 64'd0);
      tick();
      #2 chk("first_req_latency", 64'(ireq_valid_o), 64'd1);
      tick();
      tick();
      ireq_ready_i = 1'b0;
      #2 chk("credits_exhausted", 64'(credits_o), 64'd0);
      chk("stall_no_req", 64'(ireq_valid_o), 64'd0);
      tick();

      // One response using a single slot, then two pops.
      irsp_valid_i = 1'b1; irsp_vaddr_i = a('h0); realign_instr_valid_i = 2'b01;
      exp_rsp.push_back(a('h0));
      tick();
      irsp_valid_i = 1'b0; iq_pop_i = 1'b1;
      #2 chk("credits_after_rsp", 64'(credits_o), 64'd1);
      tick();
      tick();
      iq_pop_i = 1'b0;
      #2 chk("credits_after_pops", 64'(credits_o), 64'd3);

      // Back-pressure: request held stable, no credit change.
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_valid", 64'(ireq_valid_o), 64'd1);
         chk("hold_vaddr", 64'(ireq_vaddr_o), 64'(a('h8)));
         chk("hold_credits", 64'(credits_o), 64'd3);
         tick();
      end
      exp_req.push_back(a('h8));
      ireq_ready_i = 1'b1;
      tick();

      // Response for 0x4 (one slot used), then issue + response + pop together.
      irsp_valid_i = 1'b1; irsp_vaddr_i = a('h4); realign_instr_valid_i = 2'b10;
      exp_rsp.push_back(a('h4));
      tick();
      irsp_valid_i = 1'b0;
      #2 chk("credits_pre_combined", 64'(credits_o), 64'd2);
      tick();
      irsp_valid_i = 1'b1; irsp_vaddr_i = a('h8); realign_instr_valid_i = 2'b01;
      iq_pop_i = 1'b1;
      exp_rsp.push_back(a('h8));
      exp_req.push_back(a('hC));
      #2 chk("combined_issue", 64'(ireq_valid_o), 64'd1);
      tick();
      irsp_valid_i = 1'b0; iq_pop_i = 1'b0;
      exp_req.push_back(a('h10));
      #2 chk("credits_combined", 64'(credits_o), 64'd2);
      tick();

      // Flush with two requests outstanding.
      flush_i = 1'b1; flush_addr_i = a('h102);
      #2 chk("flush_pulse", 64'(realign_flush_o), 64'd1);
      chk("flush_no_req", 64'(ireq_valid_o), 64'd0);
      tick();
      flush_i = 1'b0; ireq_ready_i = 1'b0;
      #2 chk("flush_pulse_end", 64'(realign_flush_o), 64'd0);
      chk("flush_vaddr", 64'(ireq_vaddr_o), 64'(a('h102)));
      chk("flush_credits", 64'(credits_o), 64'd0);
      tick();
      irsp_valid_i = 1'b1; irsp_vaddr_i = a('hC); realign_instr_valid_i = 2'b11;
      #2 chk("kill_rsp0", 64'(realign_valid_o), 64'd0);
      tick();
      irsp_vaddr_i = a('h10);
      #2 chk("kill_rsp1", 64'(realign_valid_o), 64'd0);
      tick();
      irsp_valid_i = 1'b0;
      #2 chk("credits_after_kill", 64'(credits_o), 64'd4);
      exp_req.push_back(a('h102));
      exp_req.push_back(a('h104));
      ireq_ready_i = 1'b1;
      tick();
      tick();

      // Live responses after the flush.
      irsp_valid_i = 1'b1; irsp_vaddr_i = a('h102); realign_instr_valid_i = 2'b01;
      exp_rsp.push_back(a('h102));
      tick();
      irsp_vaddr_i = a('h104); realign_instr_valid_i = 2'b11;
      exp_rsp.push_back(a('h104));
      tick();
      irsp_valid_i = 1'b0; ireq_ready_i = 1'b0; iq_pop_i = 1'b1;
      #2 chk("credits_post_flush_rsp", 64'(credits_o), 64'd1);
      tick(); tick(); tick();
      iq_pop_i = 1'b0;
      #2 chk("credits_refilled", 64'(credits_o), 64'd4);
      exp_req.push_back(a('h108));
      exp_req.push_back(a('h10C));
      ireq_ready_i = 1'b1;
      tick();
      tick();
      tick();

      // Asynchronous reset mid-stream with two requests outstanding.
      rst_ni = 1'b0;
      #1;
      chk("async_rst_credits", 64'(credits_o), 64'd4);
      chk("async_rst_valid", 64'(ireq_valid_o), 64'd0);
      chk("async_rst_vaddr", 64'(ireq_vaddr_o), 64'(BASE));
      tick(); tick();
      exp_req.push_back(a('h0));
      rst_ni = 1'b1;
      #2 chk("reboot_no_req", 64'(ireq_valid_o), 64'd0);
      tick();
      #2 chk("reboot_first_req", 64'(ireq_valid_o), 64'd1);
      tick();
      ireq_ready_i = 1'b0;
      tick(); tick();

      chk("req_queue_drained", 64'(exp_req.size()), 64'd0);
      chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
